frame_encoder_gen2: RTL and testbench

//  Parametrised single-module successor of the FIFO->CRC->whitening->framing chain. Accepts one PHY

---
 rtl/frame_encoder_gen2.sv | 186 ++++++++++++++++++
 tb/tb_frame_encoder_gen2.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_encoder_gen2.sv
// PHY frame serialiser: byte FIFO, CRC-16/32, PN9 whitening and SHR/PHR framing,
// streamed one bit per clock from the first preamble bit to the last FCS bit.
module frame_encoder_gen2 #(
  parameter int          FIFO_ADDR_W    = 4,
  parameter int          PREAMBLE_BYTES = 4,
  parameter logic [15:0] SFD_VAL        = 16'h904E,
  parameter int          MAX_LEN        = 2047,
  parameter logic [8:0]  PN9_SEED       = 9'h1FF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        frame_start_i,
  input  logic [10:0] frame_len_i,
  input  logic        fcs_type_i,
  input  logic        whiten_en_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        out_bit_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int DEPTH = 2**FIFO_ADDR_W;
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_SFD = 3'd2,
                         S_PHR  = 3'd3, S_PSDU = 3'd4, S_FCS = 3'd5;
  localparam logic [13:0]          PRE_LAST = 14'(PREAMBLE_BYTES*8-1);
  localparam logic [11:0]          MAX_L12  = 12'(MAX_LEN);
  localparam logic [FIFO_ADDR_W:0] DEPTH_V  = (FIFO_ADDR_W+1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] PTR_ONE  = (FIFO_ADDR_W+1)'(1);

  logic [2:0]           state_q, state_d;
  logic [13:0]          cnt_q, cnt_d;
  logic [10:0]          len_q, len_d, plen_q, plen_d, acc_q, acc_d;
  logic                 fcs_q, fcs_d, wht_q, wht_d, err_q, err_d;
  logic [31:0]          crc_q, crc_d;
  logic [8:0]           pn_q, pn_d;
  logic [7:0]           cur_q, cur_d;
  logic [FIFO_ADDR_W:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]           mem_q [DEPTH];

  logic [FIFO_ADDR_W:0] fill;
  logic [7:0]           head;
  logic [15:0]          phr;
  logic                 empty, full, wr_en, underflow, dbit, cbit, fb, legal;
  logic                 psdu_end, fcs_end;

  assign fill      = wr_q - rd_q;
  assign empty     = (fill == '0);
  assign full      = (fill == DEPTH_V);
  assign head      = mem_q[rd_q[FIFO_ADDR_W-1:0]];
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;
  assign in_ready_o = busy_o & ~full & (acc_q < plen_q);
  // A byte slot with nothing queued ends the frame in the very cycle it is due.
  assign underflow = (state_q == S_PSDU) && (cnt_q[2:0] == 3'd0) && empty;
  assign wr_en     = in_valid_i & in_ready_o & ~underflow;
  assign dbit      = (cnt_q[2:0] == 3'd0) ? head[0] : cur_q[cnt_q[2:0]];
  assign cbit      = fcs_q ? ~crc_q[~cnt_q[4:0]] : crc_q[{1'b0, ~cnt_q[3:0]}];
  assign fb        = (fcs_q ? crc_q[31] : crc_q[15]) ^ dbit;
  assign psdu_end  = (cnt_q == {plen_q - 11'd1, 3'b111});
  assign fcs_end   = (cnt_q[4:0] == (fcs_q ? 5'd31 : 5'd15));
  assign legal     = ({1'b0, frame_len_i} <= MAX_L12) &&
                     (frame_len_i >= (fcs_type_i ? 11'd5 : 11'd3));
  assign out_valid_o = busy_o & ~underflow;
  assign out_last_o  = (state_q == S_FCS) & fcs_end;

  always_comb begin
    phr = '0;
    phr[3] = fcs_q;
    phr[4] = wht_q;
    for (int i = 0; i < 11; i++) phr[5+i] = len_q[10-i];
  end

  always_comb begin
    out_bit_o = 1'b0;
    case (state_q)
      S_PRE:   out_bit_o = ~cnt_q[0];
      S_SFD:   out_bit_o = SFD_VAL[cnt_q[3:0]];
      S_PHR:   out_bit_o = phr[cnt_q[3:0]];
      S_PSDU:  out_bit_o = (dbit ^ (wht_q & pn_q[0])) & ~underflow;
      S_FCS:   out_bit_o = cbit ^ (wht_q & pn_q[0]);
      default: out_bit_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 14'd1;
    len_d   = len_q;
    plen_d  = plen_q;
    fcs_d   = fcs_q;
    wht_d   = wht_q;
    crc_d   = crc_q;
    pn_d    = pn_q;
    cur_d   = cur_q;
    err_d   = 1'b0;
    wr_d    = wr_q + {{FIFO_ADDR_W{1'b0}}, wr_en};
    rd_d    = rd_q;
    acc_d   = acc_q + {10'd0, wr_en};
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (frame_start_i) begin
          if (legal) begin
            state_d = S_PRE;
            len_d   = frame_len_i;
            plen_d  = frame_len_i - (fcs_type_i ? 11'd4 : 11'd2);
            fcs_d   = fcs_type_i;
            wht_d   = whiten_en_i;
            acc_d   = '0;
            crc_d   = fcs_type_i ? 32'hFFFF_FFFF : 32'h0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRE: if (cnt_q == PRE_LAST) begin state_d = S_SFD; cnt_d = '0; end
      S_SFD: if (cnt_q[3:0] == 4'd15) begin state_d = S_PHR; cnt_d = '0; end
      S_PHR: if (cnt_q[3:0] == 4'd15) begin
        state_d = S_PSDU;
        cnt_d   = '0;
        pn_d    = PN9_SEED;
      end
      S_PSDU: begin
        if (underflow) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wr_d    = '0;
          rd_d    = '0;
        end else begin
          if (cnt_q[2:0] == 3'd0) begin
            rd_d  = rd_q + PTR_ONE;
            cur_d = head;
          end
          crc_d = fcs_q ? ({crc_q[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0))
                        : ({16'h0, crc_q[14:0], 1'b0} ^ (fb ? 32'h0000_1021 : 32'h0));
          pn_d  = {pn_q[0] ^ pn_q[5], pn_q[8:1]};
          if (psdu_end) begin state_d = S_FCS; cnt_d = '0; end
        end
      end
      S_FCS: begin
        pn_d = {pn_q[0] ^ pn_q[5], pn_q[8:1]};
        if (fcs_end) begin state_d = S_IDLE; cnt_d = '0; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[FIFO_ADDR_W-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      plen_q  <= '0;
      acc_q   <= '0;
      fcs_q   <= 1'b0;
      wht_q   <= 1'b0;
      err_q   <= 1'b0;
      crc_q   <= '0;
      pn_q    <= PN9_SEED;
      cur_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      plen_q  <= plen_d;
      acc_q   <= acc_d;
      fcs_q   <= fcs_d;
      wht_q   <= wht_d;
      err_q   <= err_d;
      crc_q   <= crc_d;
      pn_q    <= pn_d;
      cur_q   <= cur_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_frame_encoder_gen2.sv
// Bench for frame_encoder_gen2: directed and random frames compared cycle by cycle
// against an expected-bit list built from the framing, CRC and PN9 rules.
module tb_frame_encoder_gen2;
  localparam int          PRE   = 4;
  localparam int          DEPTH = 16;
  localparam int          S0    = PRE*8 + 32;
  localparam logic [15:0] SFD   = 16'h904E;
  localparam logic [8:0]  SEED  = 9'h1FF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        frame_start = 1'b0, fcs_type = 1'b0, whiten_en = 1'b0, in_valid = 1'b0;
  logic [10:0] frame_len = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_bit, out_valid, out_last, busy, err;

  frame_encoder_gen2 dut (
    .clk_i(clk), .reset_n_i(rst_n), .frame_start_i(frame_start), .frame_len_i(frame_len),
    .fcs_type_i(fcs_type), .whiten_en_i(whiten_en), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .out_bit_o(out_bit), .out_valid_o(out_valid), .out_last_o(out_last),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  logic [7:0] pay [0:2047];
  bit   exp_bits[$];
  bit   pn_o[$];
  bit   m_busy = 1'b0, m_err = 1'b0;
  int   m_pos = 0, m_plen = 0, m_acc = 0;
  int   src_lim = 0;
  bit   src_rand = 1'b0, spur = 1'b0;
  int   n_vld = 0, n_last = 0, n_acc = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // PN9 output sequence: seed bits first, then o[j] = o[j-9] ^ o[j-4].
  function automatic void gen_pn(int n);
    logic [8:0] s = SEED;
    pn_o.delete();
    for (int j = 0; j < n; j++) pn_o.push_back((j < 9) ? s[j] : (pn_o[j-9] ^ pn_o[j-4]));
  endfunction

  function automatic logic [31:0] crc_of(bit f, int n);
    logic [31:0] c = f ? 32'hFFFF_FFFF : 32'h0;
    bit fbk;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        fbk = (f ? c[31] : c[15]) ^ pay[k][b];
        if (f) c = {c[30:0], 1'b0} ^ (fbk ? 32'h04C1_1DB7 : 32'h0);
        else   c = {16'h0, c[14:0], 1'b0} ^ (fbk ? 32'h0000_1021 : 32'h0);
      end
    return f ? ~c : c;
  endfunction

  function automatic void build(logic [10:0] len, bit f, bit w);
    int pl = int'(len) - (f ? 4 : 2);
    int fw = f ? 32 : 16;
    logic [15:0] sfd = SFD;
    logic [31:0] c = crc_of(f, pl);
    bit d;
    exp_bits.delete();
    for (int i = 0; i < PRE*8; i++) exp_bits.push_back((i % 2) == 0);
    for (int i = 0; i < 16; i++) exp_bits.push_back(sfd[i]);
    for (int i = 0; i < 16; i++)
      exp_bits.push_back((i < 3) ? 1'b0 : (i == 3) ? f : (i == 4) ? w : len[15-i]);
    gen_pn(8*pl + fw);
    for (int j = 0; j < 8*pl + fw; j++) begin
      d = (j < 8*pl) ? pay[j/8][j%8] : c[fw-1-(j-8*pl)];
      exp_bits.push_back(d ^ (w & pn_o[j]));
    end
  endfunction

  // Compare outputs for the current cycle, then advance the model over the coming edge.
  task automatic step();
    bit uf = 0, ev = 0, el = 0, er = 0;
    int pops = 0, fo;
    if (m_busy) begin
      if (m_pos >= S0 && m_pos < S0 + 8*m_plen && ((m_pos - S0) % 8) == 0 &&
          m_acc == (m_pos - S0) / 8) uf = 1;
      if (m_pos > S0) pops = ((m_pos - S0 + 7) / 8 > m_plen) ? m_plen : (m_pos - S0 + 7) / 8;
      ev = !uf;
      el = !uf && (m_pos == exp_bits.size() - 1);
      er = ((m_acc - pops) < DEPTH) && (m_acc < m_plen);
    end
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
    chk("out_valid", out_valid, ev);
    chk("out_last", out_last, el);
    chk("in_ready", in_ready, er);
    if (ev) chk("out_bit", out_bit, exp_bits[m_pos]);
    n_vld  += int'(out_valid);
    n_last += int'(out_last);
    n_err  += int'(err);
    if (in_valid && in_ready) n_acc++;
    if (!rst_n) begin
      m_busy = 0; m_err = 0;
    end else if (!m_busy) begin
      m_err = 0;
      if (frame_start) begin
        fo = fcs_type ? 4 : 2;
        if (int'(frame_len) > fo) begin
          build(frame_len, fcs_type, whiten_en);
          m_busy = 1; m_pos = 0; m_acc = 0; m_plen = int'(frame_len) - fo;
        end else m_err = 1;
      end
    end else begin
      m_err = 0;
      if (uf) begin
        m_busy = 0; m_err = 1;
      end else begin
        if (in_valid && er) m_acc++;
        if (m_pos == exp_bits.size() - 1) m_busy = 0;
        else m_pos++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    in_valid = (m_acc < src_lim) && (!src_rand || ($urandom_range(3) != 0));
    in_data  = pay[(m_acc < 2048) ? m_acc : 0];
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      if (spur && busy && $urandom_range(15) == 0) begin
        frame_start = 1'b1; frame_len = 11'($urandom); fcs_type = 1'($urandom);
      end
      n++;
    end
    chk("frame_done", busy, 0);
  endtask

  task automatic run_frame(int len, bit f, bit w);
    frame_start = 1'b1; frame_len = 11'(len); fcs_type = f; whiten_en = w;
    cycle();
    wait_done(20000);
    cycle();
    cycle();
  endtask

  task automatic fill_pay(int n);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
  endtask

  initial begin
    int b_vld, b_last, b_err, b_acc, len;
    logic [15:0] v16;
    logic [13:0] v14;
    for (int i = 0; i < 2048; i++) pay[i] = '0;
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    cycle();

    // Pin the reference model itself.
    pay[0] = 8'h01;
    chk("crc16_pin", crc_of(1'b0, 1), 32'h0000_9188);
    gen_pn(14);
    for (int j = 0; j < 14; j++) v14[j] = pn_o[j];
    chk("pn9_pin", v14, 14'b10000111111111);

    // T2: plain CRC-16 frame
    pay[0] = 8'h40; pay[1] = 8'h00; pay[2] = 8'h56;
    src_lim = 2048; src_rand = 0;
    build(11'd5, 1'b0, 1'b0);
    chk("t2_len_model", exp_bits.size(), 104);
    for (int i = 0; i < 16; i++) v16[i] = exp_bits[48+i];
    chk("t2_phr_model", v16, 16'hA000);
    b_vld = n_vld; b_last = n_last;
    run_frame(5, 0, 0);
    chk("t2_bits", n_vld - b_vld, 104);
    chk("t2_last", n_last - b_last, 1);

    // T3: CRC-32 with whitening over the same payload
    build(11'd7, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) v16[i] = exp_bits[48+i];
    chk("t3_phr_model", v16, 16'hE018);
    b_vld = n_vld;
    run_frame(7, 1, 1);
    chk("t3_bits", n_vld - b_vld, 64 + 24 + 32);

    // T4: illegal lengths
    b_vld = n_vld; b_err = n_err;
    run_frame(2, 0, 0);
    run_frame(3, 1, 0);
    chk("t4_err", n_err - b_err, 2);
    chk("t4_valid", n_vld - b_vld, 0);

    // T5: source stops after 10 bytes
    fill_pay(38); src_lim = 10;
    b_vld = n_vld; b_last = n_last; b_err = n_err; b_acc = n_acc;
    run_frame(40, 0, 0);
    chk("t5_bits", n_vld - b_vld, 144);
    chk("t5_last", n_last - b_last, 0);
    chk("t5_err", n_err - b_err, 1);
    chk("t5_acc", n_acc - b_acc, 10);

    // T6: 32-byte payload through a 16-deep FIFO, then back-to-back start
    fill_pay(32); src_lim = 2048;
    b_acc = n_acc; b_last = n_last;
    frame_start = 1'b1; frame_len = 11'd34; fcs_type = 1'b0; whiten_en = 1'b1;
    cycle();
    wait_done(20000);
    chk("t6_acc", n_acc - b_acc, 32);
    fill_pay(8);
    frame_start = 1'b1; frame_len = 11'd12; fcs_type = 1'b1; whiten_en = 1'b0;
    cycle();
    chk("t6_b2b_busy", busy, 1);
    wait_done(20000);
    cycle(); cycle();
    chk("t6_last", n_last - b_last, 2);

    // T1: reset in the middle of the payload
    fill_pay(18); b_last = n_last;
    frame_start = 1'b1; frame_len = 11'd20; fcs_type = 1'b0; whiten_en = 1'b0;
    cycle();
    repeat (70) cycle();
    rst_n = 1'b0;
    cycle();
    chk("t1_busy", busy, 0);
    chk("t1_ready", in_ready, 0);
    rst_n = 1'b1;
    cycle();
    chk("t1_last", n_last - b_last, 0);
    fill_pay(8);
    run_frame(10, 0, 1);
    chk("t1_restart", n_last - b_last, 1);

    // Random frames, random source gaps, spurious requests while busy
    src_rand = 1; spur = 1;
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(3, 50);
      fill_pay(len);
      run_frame(len, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
